// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staged reset release sequencer gated by PLL lock and software reset
// Define RST_SEQ_STATUS_EN to add the o_state and o_lock_loss_cnt status ports.
module rst_seq #(
  parameter int P_STAGES    = 4,
  parameter int P_LOCK_CYC  = 16,
  parameter int P_GAP       = 8,
  parameter int P_SWRST_CYC = 32
) (
  input  logic                i_clk,
  input  logic                i_srst_n,
  input  logic                i_pll_lock,
  input  logic                i_sw_rst,
  output logic [P_STAGES-1:0] o_rst_n,
  output logic                o_ready
`ifdef RST_SEQ_STATUS_EN
  ,
  output logic [2:0]          o_state,
  output logic [7:0]          o_lock_loss_cnt
`endif
);

  localparam int LOCK_W = (P_LOCK_CYC > 1) ? $clog2(P_LOCK_CYC) : 1;
  localparam int GAP_W  = (P_GAP > 1) ? $clog2(P_GAP) : 1;
  localparam int SW_W   = (P_SWRST_CYC > 1) ? $clog2(P_SWRST_CYC) : 1;
  localparam int IDX_W  = (P_STAGES > 1) ? $clog2(P_STAGES) : 1;

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(P_LOCK_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(P_GAP - 1);
  localparam logic [SW_W-1:0]   SW_LAST   = SW_W'(P_SWRST_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(P_STAGES - 1);

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_DEBOUNCE  = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_HOLD      = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [SW_W-1:0]     sw_cnt_q, sw_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [P_STAGES-1:0] rst_n_d;
  logic                ready_d;

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      state_q    <= ST_RST;
      lock_cnt_q <= '0;
      gap_cnt_q  <= '0;
      sw_cnt_q   <= '0;
      idx_q      <= '0;
      o_rst_n    <= '0;
      o_ready    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sw_cnt_q   <= sw_cnt_d;
      idx_q      <= idx_d;
      o_rst_n    <= rst_n_d;
      o_ready    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sw_cnt_d   = sw_cnt_q;
    idx_d      = idx_q;
    rst_n_d    = o_rst_n;
    ready_d    = o_ready;
    case (state_q)
      ST_RST: begin
        state_d = ST_WAIT_LOCK;
        rst_n_d = '0;
        ready_d = 1'b0;
      end
      ST_WAIT_LOCK: begin
        if (i_pll_lock) begin
          state_d    = ST_DEBOUNCE;
          lock_cnt_d = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!i_pll_lock) begin
          state_d = ST_WAIT_LOCK;
        end else if (i_sw_rst) begin
          state_d  = ST_HOLD;
          sw_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d   = ST_RELEASE;
          idx_d     = '0;
          gap_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      // Lock loss outranks a software request; both drop every stage at once.
      ST_RELEASE, ST_RUN: begin
        if (!i_pll_lock) begin
          state_d = ST_WAIT_LOCK;
          rst_n_d = '0;
          ready_d = 1'b0;
        end else if (i_sw_rst) begin
          state_d  = ST_HOLD;
          sw_cnt_d = '0;
          rst_n_d  = '0;
          ready_d  = 1'b0;
        end else if (state_q == ST_RELEASE) begin
          if (gap_cnt_q == GAP_LAST) begin
            rst_n_d[idx_q] = 1'b1;
            gap_cnt_d      = '0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        rst_n_d = '0;
        ready_d = 1'b0;
        if (sw_cnt_q == SW_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          sw_cnt_d = sw_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RST;
        rst_n_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

`ifdef RST_SEQ_STATUS_EN
  logic [7:0] loss_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      loss_cnt_q <= '0;
    end else if ((state_q == ST_RELEASE || state_q == ST_RUN) && !i_pll_lock &&
                 loss_cnt_q != 8'hFF) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign o_state         = state_q;
  assign o_lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - directed and random checks of rst_seq against a timeline model
module tb_rst_seq;

  localparam int STAGES = 4;
  localparam int LOCK   = 16;
  localparam int GAP    = 8;
  localparam int SWR    = 32;

  localparam int M_RST  = 0;
  localparam int M_WAIT = 1;
  localparam int M_SEQ  = 2;
  localparam int M_HOLD = 3;

  logic              i_clk = 1'b0;
  logic              i_srst_n = 1'b0;
  logic              i_pll_lock = 1'b0;
  logic              i_sw_rst = 1'b0;
  logic [STAGES-1:0] o_rst_n;
  logic              o_ready;
`ifdef RST_SEQ_STATUS_EN
  logic [2:0]        o_state;
  logic [7:0]        o_lock_loss_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Model: cycles since debounce start (m_n) or since hold start (m_h).
  int m_mode = M_RST;
  int m_n    = 0;
  int m_h    = 0;
  int m_loss = 0;

  rst_seq #(
    .P_STAGES(STAGES), .P_LOCK_CYC(LOCK), .P_GAP(GAP), .P_SWRST_CYC(SWR)
  ) dut (
    .i_clk(i_clk),
    .i_srst_n(i_srst_n),
    .i_pll_lock(i_pll_lock),
    .i_sw_rst(i_sw_rst),
    .o_rst_n(o_rst_n),
    .o_ready(o_ready)
`ifdef RST_SEQ_STATUS_EN
    ,
    .o_state(o_state),
    .o_lock_loss_cnt(o_lock_loss_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int released();
    int k;
    if (m_mode != M_SEQ || m_n < LOCK) return 0;
    k = (m_n - LOCK) / GAP;
    return (k > STAGES) ? STAGES : k;
  endfunction

  function automatic int exp_state();
    case (m_mode)
      M_RST:   return 0;
      M_WAIT:  return 1;
      M_HOLD:  return 5;
      default: return (m_n < LOCK) ? 2 : ((released() < STAGES) ? 3 : 4);
    endcase
  endfunction

  task automatic model_edge(input logic srst, input logic lock, input logic sw);
    if (!srst) begin
      m_mode = M_RST;
      m_loss = 0;
    end else begin
      case (m_mode)
        M_RST: m_mode = M_WAIT;
        M_WAIT: if (lock) begin m_mode = M_SEQ; m_n = 0; end
        M_SEQ: begin
          if (!lock) begin
            if (m_n >= LOCK && m_loss < 255) m_loss++;
            m_mode = M_WAIT;
          end else if (sw) begin
            m_mode = M_HOLD;
            m_h = 0;
          end else if (m_n < 1000) begin
            m_n++;
          end
        end
        default: begin
          m_h++;
          if (m_h == SWR) m_mode = M_WAIT;
        end
      endcase
    end
  endtask

  task automatic step(input logic srst, input logic lock, input logic sw);
    int k;
    i_srst_n   = srst;
    i_pll_lock = lock;
    i_sw_rst   = sw;
    @(posedge i_clk);
    model_edge(srst, lock, sw);
    #1;
    k = released();
    chk("model_rst_n", 32'(o_rst_n), 32'((1 << k) - 1));
    chk("model_ready", 32'(o_ready), 32'(k == STAGES));
`ifdef RST_SEQ_STATUS_EN
    chk("model_state", 32'(o_state), 32'(exp_state()));
    chk("model_loss", 32'(o_lock_loss_cnt), 32'(m_loss));
`endif
  endtask

  // Caller has just taken the edge where lock is first sampled high.
  task automatic run_seq(input string tag);
    for (int i = 1; i <= 48; i++) begin
      step(1'b1, 1'b1, 1'b0);
      case (i)
        23: chk({tag, "_t23"}, 32'(o_rst_n), 32'h0);
        24: chk({tag, "_t24"}, 32'(o_rst_n), 32'h1);
        32: chk({tag, "_t32"}, 32'(o_rst_n), 32'h3);
        40: chk({tag, "_t40"}, 32'(o_rst_n), 32'h7);
        47: chk({tag, "_t47_ready"}, 32'(o_ready), 32'h0);
        48: begin
          chk({tag, "_t48"}, 32'(o_rst_n), 32'hF);
          chk({tag, "_t48_ready"}, 32'(o_ready), 32'h1);
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    chk("reset_rst_n", 32'(o_rst_n), 32'h0);
    chk("reset_ready", 32'(o_ready), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    step(1'b1, 1'b1, 1'b0);
    run_seq("first");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);

    step(1'b1, 1'b0, 1'b0);
    chk("runloss_rst_n", 32'(o_rst_n), 32'h0);
    chk("runloss_ready", 32'(o_ready), 32'h0);
`ifdef RST_SEQ_STATUS_EN
    chk("runloss_cnt", 32'(o_lock_loss_cnt), 32'd1);
`endif

    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    run_seq("debounce");

    step(1'b1, 1'b1, 1'b1);
    chk("swrst_rst_n", 32'(o_rst_n), 32'h0);
    chk("swrst_ready", 32'(o_ready), 32'h0);
    for (int i = 1; i <= 81; i++) begin
      step(1'b1, 1'b1, (i == 10));
      if (i == 56) chk("hold_t56", 32'(o_rst_n), 32'h0);
      if (i == 57) chk("hold_t57", 32'(o_rst_n), 32'h1);
      if (i == 81) chk("hold_run", 32'(o_rst_n), 32'hF);
    end

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 34; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("both_rst_n", 32'(o_rst_n), 32'h0);
`ifdef RST_SEQ_STATUS_EN
    chk("both_state", 32'(o_state), 32'd1);
`endif
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 24) chk("both_resume", 32'(o_rst_n), 32'h1);
    end

    step(1'b0, 1'b1, 1'b0);
    chk("srst_rst_n", 32'(o_rst_n), 32'h0);
    chk("srst_ready", 32'(o_ready), 32'h0);
`ifdef RST_SEQ_STATUS_EN
    chk("srst_state", 32'(o_state), 32'd0);
    chk("srst_cnt", 32'(o_lock_loss_cnt), 32'd0);
`endif

    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 1499) != 0),
           ($urandom_range(0, 149) != 0),
           ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
